// File: rtl/ov5640_cfg_pkg.sv
`default_nettype none
// ============================================================================
// ov5640_cfg_pkg
// Shared types, constants and the OV5640 init table image for the sequencer.
// Revision: 1.0
// ============================================================================
package ov5640_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_ISSUE     = 4'd3,
        ST_WAIT_RDY  = 4'd4,
        ST_DELAY     = 4'd5,
        ST_NEXT_CAM  = 4'd6,
        ST_HPS_ISSUE = 4'd7,
        ST_HPS_WAIT  = 4'd8
    } state_t;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] addr;
    } entry_t;

    localparam logic [15:0] ADDR_DELAY = 16'hFFFF;
    localparam logic [15:0] ADDR_END   = 16'hFFFE;

    // Soft reset, settle 1 ms, clock-source select; unused slots read as end marker.
    function automatic entry_t init_entry(input int unsigned idx);
        entry_t e;
        case (idx)
            0:       e = {8'h82, 16'h3008};
            1:       e = {8'h01, ADDR_DELAY};
            2:       e = {8'h00, ADDR_DELAY};
            3:       e = {8'h11, 16'h3103};
            default: e = {8'h00, ADDR_END};
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov5640_init_rom.sv
`default_nettype none
// ============================================================================
// ov5640_init_rom
// Synchronous INIT_DEPTH x 24 init-table ROM, one cycle read latency.
// Revision: 1.0
// ============================================================================
module ov5640_init_rom
    import ov5640_cfg_pkg::*;
#(
    parameter int INIT_DEPTH = 512
) (
    input  logic                          clk_sys,
    input  logic [$clog2(INIT_DEPTH)-1:0] addr,
    output entry_t                        q
);

    always_ff @(posedge clk_sys) begin
        q <= init_entry(32'(addr));
    end

endmodule
`default_nettype wire

// File: rtl/ov5640_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// ov5640_cfg_sequencer
// Walks the init table for each selected camera and arbitrates HPS writes
// onto a single SCCB master.
// Revision: 1.0
// ============================================================================
module ov5640_cfg_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter int CLK_PER_MS = 50000,
    parameter int INIT_DEPTH = 512
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        init_start,
    input  logic [1:0]  cam_sel,
    input  logic        hps_valid,
    input  logic [15:0] hps_addr,
    input  logic [7:0]  hps_data,
    input  logic        hps_cam,
    output logic        hps_ready,
    input  logic        ready_ov5640,
    output logic        start_ov5640,
    output logic [15:0] address_ov5640,
    output logic [7:0]  data_ov5640,
    output logic        cam_id,
    output logic        init_busy,
    output logic [1:0]  init_done
);

    localparam int AW = $clog2(INIT_DEPTH);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(CLK_PER_MS - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(INIT_DEPTH - 1);

    state_t        r_state;
    state_t        w_state_n;
    entry_t        w_rom_q;
    logic [AW-1:0] r_idx;
    logic [7:0]    r_ms;
    logic [PW-1:0] r_pre;
    logic [1:0]    r_cam_sel;
    logic          r_cam;
    logic          r_first;
    logic          r_busy;
    logic [1:0]    r_done;
    logic [15:0]   r_hold_addr;
    logic [7:0]    r_hold_data;
    logic          r_hold_cam;
    logic [15:0]   r_hps_addr;
    logic [7:0]    r_hps_data;
    logic          r_hps_cam;

    logic        w_start;
    logic        w_hps_ready;
    logic        w_init_go;
    logic        w_hps_go;
    logic        w_next_idx;
    logic        w_load_delay;
    logic        w_cam_done;
    logic        w_cam1_go;
    logic        w_finish;
    logic [15:0] w_issue_addr;
    logic [7:0]  w_issue_data;
    logic        w_issue_cam;

    ov5640_init_rom #(
        .INIT_DEPTH (INIT_DEPTH)
    ) u_rom (
        .clk_sys (clk_sys),
        .addr    (r_idx),
        .q       (w_rom_q)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_start      = 1'b0;
        w_hps_ready  = 1'b0;
        w_init_go    = 1'b0;
        w_hps_go     = 1'b0;
        w_next_idx   = 1'b0;
        w_load_delay = 1'b0;
        w_cam_done   = 1'b0;
        w_cam1_go    = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (init_start && (cam_sel != 2'b00)) begin
                    w_init_go = 1'b1;
                    w_state_n = ST_FETCH;
                end else if (hps_valid) begin
                    w_hps_ready = 1'b1;
                    w_hps_go    = 1'b1;
                    w_state_n   = ST_HPS_ISSUE;
                end
            end
            ST_FETCH: w_state_n = ST_DECODE;
            ST_DECODE: begin
                if ((w_rom_q.addr == ADDR_END) || (r_idx == LAST_IDX)) begin
                    w_state_n = ST_NEXT_CAM;
                end else if (w_rom_q.addr == ADDR_DELAY) begin
                    w_load_delay = 1'b1;
                    w_state_n    = ST_DELAY;
                end else begin
                    w_state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ready_ov5640) begin
                    w_start   = 1'b1;
                    w_state_n = ST_WAIT_RDY;
                end
            end
            // The master only drops ready a cycle after the strobe, so the
            // first post-strobe cycle cannot be trusted.
            ST_WAIT_RDY: begin
                if (!r_first && ready_ov5640) begin
                    w_next_idx = 1'b1;
                    w_state_n  = ST_FETCH;
                end
            end
            ST_DELAY: begin
                if ((r_ms == 8'd0) || ((r_pre == '0) && (r_ms == 8'd1))) begin
                    w_next_idx = 1'b1;
                    w_state_n  = ST_FETCH;
                end
            end
            ST_NEXT_CAM: begin
                w_cam_done = 1'b1;
                if (!r_cam && r_cam_sel[1]) begin
                    w_cam1_go = 1'b1;
                    w_state_n = ST_FETCH;
                end else begin
                    w_finish  = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            ST_HPS_ISSUE: begin
                if (ready_ov5640) begin
                    w_start   = 1'b1;
                    w_state_n = ST_HPS_WAIT;
                end
            end
            ST_HPS_WAIT: begin
                if (!r_first && ready_ov5640) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign w_issue_addr = (r_state == ST_HPS_ISSUE) ? r_hps_addr : w_rom_q.addr;
    assign w_issue_data = (r_state == ST_HPS_ISSUE) ? r_hps_data : w_rom_q.data;
    assign w_issue_cam  = (r_state == ST_HPS_ISSUE) ? r_hps_cam  : r_cam;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_ms        <= 8'd0;
            r_pre       <= '0;
            r_cam_sel   <= 2'b00;
            r_cam       <= 1'b0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 2'b00;
            r_hold_addr <= 16'd0;
            r_hold_data <= 8'd0;
            r_hold_cam  <= 1'b0;
            r_hps_addr  <= 16'd0;
            r_hps_data  <= 8'd0;
            r_hps_cam   <= 1'b0;
        end else begin
            r_first <= w_start;
            if (w_start) begin
                r_hold_addr <= w_issue_addr;
                r_hold_data <= w_issue_data;
                r_hold_cam  <= w_issue_cam;
            end
            if (w_init_go) begin
                r_cam_sel <= cam_sel;
                r_cam     <= ~cam_sel[0];
                r_idx     <= '0;
                r_done    <= 2'b00;
                r_busy    <= 1'b1;
            end
            if (w_hps_go) begin
                r_hps_addr <= hps_addr;
                r_hps_data <= hps_data;
                r_hps_cam  <= hps_cam;
            end
            if (w_next_idx) begin
                r_idx <= r_idx + AW'(1);
            end
            if (w_load_delay) begin
                r_ms  <= w_rom_q.data;
                r_pre <= PRE_RELOAD;
            end else if (r_state == ST_DELAY) begin
                if (r_pre == '0) begin
                    r_pre <= PRE_RELOAD;
                    r_ms  <= r_ms - 8'd1;
                end else begin
                    r_pre <= r_pre - PW'(1);
                end
            end
            if (w_cam_done) begin
                r_done[r_cam] <= 1'b1;
            end
            if (w_cam1_go) begin
                r_cam <= 1'b1;
                r_idx <= '0;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign start_ov5640   = w_start;
    assign hps_ready      = w_hps_ready;
    assign address_ov5640 = w_start ? w_issue_addr : r_hold_addr;
    assign data_ov5640    = w_start ? w_issue_data : r_hold_data;
    assign cam_id         = w_start ? w_issue_cam  : r_hold_cam;
    assign init_busy      = r_busy;
    assign init_done      = r_done;

endmodule
`default_nettype wire
